// File: rtl/issueint_pkg.sv
// Shared opcode encodings for the integer issue/execute unit.
package issueint_pkg;

   localparam int unsigned OPC_W = 4;

   typedef logic [OPC_W-1:0] opc_t;

   localparam opc_t OPC_ADD  = 4'b0000;
   localparam opc_t OPC_ADDU = 4'b0001;
   localparam opc_t OPC_SUB  = 4'b0010;
   localparam opc_t OPC_SUBU = 4'b0011;
   localparam opc_t OPC_AND  = 4'b0100;
   localparam opc_t OPC_OR   = 4'b0101;
   localparam opc_t OPC_NOR  = 4'b0111;
   localparam opc_t OPC_SLT  = 4'b1010;
   localparam opc_t OPC_SLTU = 4'b1011;

endpackage

// File: rtl/issueint_alu.sv
// Combinational integer ALU: result, carry/no-borrow and signed overflow.
module issueint_alu
   import issueint_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  opc_t              i_opcode,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_data,
   output logic              o_carry,
   output logic              o_ovf
);

   localparam int unsigned MSB = DATA_W - 1;

   logic [DATA_W:0] w_sum;
   logic [DATA_W:0] w_diff;
   logic            w_slt;
   logic            w_sltu;

   // Top bit of w_diff is the borrow out of the unsigned subtraction.
   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};
   assign w_slt  = $signed(i_a) < $signed(i_b);
   assign w_sltu = i_a < i_b;

   always_comb begin
      o_data  = '0;
      o_carry = 1'b0;
      o_ovf   = 1'b0;
      case (i_opcode)
         OPC_ADD: begin
            o_data  = w_sum[MSB:0];
            o_carry = w_sum[DATA_W];
            o_ovf   = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
         end
         OPC_ADDU: begin
            o_data  = w_sum[MSB:0];
            o_carry = w_sum[DATA_W];
         end
         OPC_SUB: begin
            o_data  = w_diff[MSB:0];
            o_carry = ~w_diff[DATA_W];
            o_ovf   = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
         end
         OPC_SUBU: begin
            o_data  = w_diff[MSB:0];
            o_carry = ~w_diff[DATA_W];
         end
         OPC_AND:  o_data = i_a & i_b;
         OPC_OR:   o_data = i_a | i_b;
         OPC_NOR:  o_data = ~(i_a | i_b);
         OPC_SLT:  o_data = {{(DATA_W-1){1'b0}}, w_slt};
         OPC_SLTU: o_data = {{(DATA_W-1){1'b0}}, w_sltu};
         default: ;
      endcase
   end

endmodule

// File: rtl/issueint_pipe.sv
// Elastic STAGES-deep integer execute pipe feeding the CDB arbiter.
// Optional squash of all in-flight ops via the flush port under `ISSUEINT_FLUSH_EN.
module issueint_pipe
   import issueint_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 6,
   parameter int unsigned STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPC_W-1:0]  in_opcode,
   input  logic [DATA_W-1:0] in_rsdata,
   input  logic [DATA_W-1:0] in_rtdata,
   input  logic [TAG_W-1:0]  in_rdtag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_rdtag,
   output logic              out_carry,
   output logic              out_overflow,
   output logic              busy
`ifdef ISSUEINT_FLUSH_EN
   ,
   input  logic              flush
`endif
);

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("issueint_pipe: STAGES must be in 1..4");
   end
   if (DATA_W < 8) begin : g_bad_width
      $error("issueint_pipe: DATA_W must be at least 8");
   end

   logic [STAGES-1:0] r_v;
   logic [STAGES-1:0] r_carry;
   logic [STAGES-1:0] r_ovf;
   logic [DATA_W-1:0] r_data [STAGES];
   logic [TAG_W-1:0]  r_tag  [STAGES];

   logic [STAGES-1:0] w_ready;
   logic [DATA_W-1:0] w_alu_data;
   logic              w_alu_carry;
   logic              w_alu_ovf;
   logic              w_flush;

`ifdef ISSUEINT_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   issueint_alu #(.DATA_W(DATA_W)) u_alu (
      .i_opcode (in_opcode),
      .i_a      (in_rsdata),
      .i_b      (in_rtdata),
      .o_data   (w_alu_data),
      .o_carry  (w_alu_carry),
      .o_ovf    (w_alu_ovf)
   );

   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_stage
      // Stage k may advance if the output drains or any stage from k onward is empty.
      assign w_ready[k] = out_ready | ~&r_v[STAGES-1:k];

      if (k == 0) begin : g_head
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_v[0]     <= 1'b0;
               r_data[0]  <= '0;
               r_tag[0]   <= '0;
               r_carry[0] <= 1'b0;
               r_ovf[0]   <= 1'b0;
            end else if (w_flush) begin
               r_v[0] <= 1'b0;
            end else if (w_ready[0]) begin
               r_v[0] <= in_valid;
               if (in_valid) begin
                  r_data[0]  <= w_alu_data;
                  r_tag[0]   <= in_rdtag;
                  r_carry[0] <= w_alu_carry;
                  r_ovf[0]   <= w_alu_ovf;
               end
            end
         end
      end else begin : g_delay
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_v[k]     <= 1'b0;
               r_data[k]  <= '0;
               r_tag[k]   <= '0;
               r_carry[k] <= 1'b0;
               r_ovf[k]   <= 1'b0;
            end else if (w_flush) begin
               r_v[k] <= 1'b0;
            end else if (w_ready[k]) begin
               r_v[k] <= r_v[k-1];
               if (r_v[k-1]) begin
                  r_data[k]  <= r_data[k-1];
                  r_tag[k]   <= r_tag[k-1];
                  r_carry[k] <= r_carry[k-1];
                  r_ovf[k]   <= r_ovf[k-1];
               end
            end
         end
      end
   end

   assign in_ready     = w_ready[0] & ~w_flush;
   assign out_valid    = r_v[STAGES-1];
   assign out_data     = r_data[STAGES-1];
   assign out_rdtag    = r_tag[STAGES-1];
   assign out_carry    = r_carry[STAGES-1];
   assign out_overflow = r_ovf[STAGES-1];
   assign busy         = |r_v;

endmodule

// File: tb/tb_issueint_pipe.sv
// Bench for issueint_pipe: queue-based reference model checked every cycle plus pinned literals.
module tb_issueint_pipe;
   import issueint_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 6;
   localparam int unsigned STAGES = 2;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  tag;
      logic        carry;
      logic        ovf;
      int          acc;
      int          cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [OPC_W-1:0]  in_opcode;
   logic [DATA_W-1:0] in_rsdata;
   logic [DATA_W-1:0] in_rtdata;
   logic [TAG_W-1:0]  in_rdtag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [TAG_W-1:0]  out_rdtag;
   logic              out_carry;
   logic              out_overflow;
   logic              busy;
   logic              flush_s;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   accepts = 0;
   exp_t q[$];
   exp_t got[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef ISSUEINT_FLUSH_EN
   logic flush;
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   issueint_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_opcode    (in_opcode),
      .in_rsdata    (in_rsdata),
      .in_rtdata    (in_rtdata),
      .in_rdtag     (in_rdtag),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_rdtag    (out_rdtag),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .busy         (busy)
`ifdef ISSUEINT_FLUSH_EN
      ,
      .flush        (flush)
`endif
   );

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Reference ALU written from the arithmetic definitions with wide integers.
   function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [5:0] tag);
      exp_t   e;
      longint sa, sb, ua, ub, r;
      e.data = 32'd0; e.carry = 1'b0; e.ovf = 1'b0; e.tag = tag; e.acc = 0; e.cyc = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         4'b0000, 4'b0001: begin
            r = ua + ub;
            e.data = r[31:0];
            e.carry = r[32];
            if (op == 4'b0000) e.ovf = (sa + sb > SMAX) || (sa + sb < SMIN);
         end
         4'b0010, 4'b0011: begin
            r = ua - ub;
            e.data = r[31:0];
            e.carry = (ua >= ub);
            if (op == 4'b0010) e.ovf = (sa - sb > SMAX) || (sa - sb < SMIN);
         end
         4'b0100: e.data = a & b;
         4'b0101: e.data = a | b;
         4'b0111: e.data = ~(a | b);
         4'b1010: e.data = {31'd0, sa < sb};
         4'b1011: e.data = {31'd0, ua < ub};
         default: ;
      endcase
      return e;
   endfunction

   // Compare process: an op accepted at edge E is visible at the output from edge E+STAGES-1.
   always @(negedge clk) begin : mon
      logic ev;
      logic ir;
      exp_t f;
      if (reset) begin
         q.delete();
      end else begin
         ev = (q.size() > 0) && (cyc >= q[0].acc + int'(STAGES) - 1);
         ir = !flush_s && ((q.size() < int'(STAGES)) || out_ready);
         check("out_valid", 64'(out_valid), 64'(ev));
         if (ev) begin
            check("out_data",  64'(out_data),     64'(q[0].data));
            check("out_rdtag", 64'(out_rdtag),    64'(q[0].tag));
            check("out_carry", 64'(out_carry),    64'(q[0].carry));
            check("out_ovf",   64'(out_overflow), 64'(q[0].ovf));
         end
         check("busy", 64'(busy), 64'(q.size() > 0));
         check("in_ready", 64'(in_ready), 64'(ir));
         if (flush_s) begin
            q.delete();
         end else begin
            if (ev && out_ready) begin
               f = q[0];
               f.cyc = cyc;
               got.push_back(f);
               void'(q.pop_front());
            end
            if (in_valid && ir) begin
               f = model(in_opcode, in_rsdata, in_rtdata, in_rdtag);
               f.acc = cyc + 1;
               q.push_back(f);
               accepts++;
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag);
      bit done;
      done = 1'b0;
      in_valid  = 1'b1;
      in_opcode = op;
      in_rsdata = a;
      in_rtdata = b;
      in_rdtag  = tag;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      if (!done) check("issue_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain();
      bit empty;
      empty = 1'b0;
      for (int i = 0; i < 100 && !empty; i++) begin
         @(posedge clk);
         #1;
         empty = (q.size() == 0);
      end
      if (!empty) check("drain_timeout", 64'(q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(string pfx);
      check({pfx, "_out_valid"}, 64'(out_valid),    64'(0));
      check({pfx, "_out_data"},  64'(out_data),     64'(0));
      check({pfx, "_out_rdtag"}, 64'(out_rdtag),    64'(0));
      check({pfx, "_out_carry"}, 64'(out_carry),    64'(0));
      check({pfx, "_out_ovf"},   64'(out_overflow), 64'(0));
      check({pfx, "_busy"},      64'(busy),         64'(0));
      check({pfx, "_in_ready"},  64'(in_ready),     64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stall_acc;
      int acc0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_opcode = '0;
      in_rsdata = '0;
      in_rtdata = '0;
      in_rdtag  = '0;
      out_ready = 1'b1;
`ifdef ISSUEINT_FLUSH_EN
      flush     = 1'b0;
`endif
      #2;
      check_zero_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Signed overflow on ADD, latency STAGES-1 edges after the accept edge.
      got.delete();
      issue(OPC_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 6'd5);
      in_valid = 1'b0;
      drain();
      check("t1_count", 64'(got.size()), 64'(1));
      if (got.size() == 1) begin
         check("t1_data",    64'(got[0].data),  64'h8000_0000);
         check("t1_ovf",     64'(got[0].ovf),   64'(1));
         check("t1_carry",   64'(got[0].carry), 64'(0));
         check("t1_tag",     64'(got[0].tag),   64'(5));
         check("t1_latency", 64'(got[0].cyc - got[0].acc), 64'(1));
      end

      // Boundary operands and the undefined opcode.
      got.delete();
      issue(OPC_SUBU, 32'h0000_0001, 32'h0000_0002, 6'd1);
      issue(OPC_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 6'd2);
      issue(OPC_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 6'd3);
      issue(4'b1111,  32'h0000_0005, 32'h0000_0003, 6'd4);
      issue(OPC_SUB,  32'h8000_0000, 32'h0000_0001, 6'd6);
      issue(OPC_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 6'd7);
      in_valid = 1'b0;
      drain();
      check("t2_count", 64'(got.size()), 64'(6));
      if (got.size() == 6) begin
         check("t2_subu_data",  64'(got[0].data),  64'hFFFF_FFFF);
         check("t2_subu_carry", 64'(got[0].carry), 64'(0));
         check("t2_subu_ovf",   64'(got[0].ovf),   64'(0));
         check("t2_slt",        64'(got[1].data),  64'(1));
         check("t2_sltu",       64'(got[2].data),  64'(0));
         check("t2_bad_data",   64'(got[3].data),  64'(0));
         check("t2_bad_tag",    64'(got[3].tag),   64'(4));
         check("t2_sub_data",   64'(got[4].data),  64'h7FFF_FFFF);
         check("t2_sub_ovf",    64'(got[4].ovf),   64'(1));
         check("t2_sub_carry",  64'(got[4].carry), 64'(1));
         check("t2_addu_data",  64'(got[5].data),  64'(0));
         check("t2_addu_carry", 64'(got[5].carry), 64'(1));
      end

      // Ten back-to-back ops retire on consecutive cycles in order.
      got.delete();
      for (int i = 0; i < 10; i++) begin
         logic [3:0] ops [10];
         ops = '{OPC_ADD, OPC_AND, OPC_OR, OPC_NOR, OPC_SUB, OPC_SLT, OPC_SLTU, OPC_ADDU,
                 OPC_SUBU, 4'b0110};
         issue(ops[i], 32'h1234_5678 * 32'(i + 1), 32'h0F0F_00FF ^ 32'(i * 977), 6'(10 + i));
      end
      in_valid = 1'b0;
      drain();
      check("t3_count", 64'(got.size()), 64'(10));
      if (got.size() == 10) begin
         for (int i = 0; i < 10; i++) begin
            check("t3_tag", 64'(got[i].tag), 64'(10 + i));
            check("t3_cycle", 64'(got[i].cyc - got[0].cyc), 64'(i));
         end
      end

      // Output stalled for 5 cycles while the issue queue keeps pushing.
      got.delete();
      out_ready = 1'b0;
      acc0 = accepts;
      fork
         begin
            for (int i = 0; i < 6; i++)
               issue(OPC_ADDU, 32'(i * 3), 32'(100 + i), 6'(30 + i));
            in_valid = 1'b0;
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            stall_acc = accepts - acc0;
            out_ready = 1'b1;
         end
      join
      drain();
      check("t4_stall_accepts", 64'(stall_acc), 64'(2));
      check("t4_count", 64'(got.size()), 64'(6));
      if (got.size() == 6) begin
         for (int i = 0; i < 6; i++) begin
            check("t4_tag",  64'(got[i].tag),  64'(30 + i));
            check("t4_data", 64'(got[i].data), 64'(100 + 4 * i));
         end
      end

      // Asynchronous reset mid-stall with two ops in flight.
      got.delete();
      out_ready = 1'b0;
      issue(OPC_OR, 32'hA5A5_0000, 32'h0000_5A5A, 6'd40);
      issue(OPC_ADD, 32'h0000_0010, 32'h0000_0020, 6'd41);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      check("t5_busy_before", 64'(busy), 64'(1));
      reset = 1'b1;
      #1;
      check_zero_outputs("t5");
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      issue(OPC_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 6'd42);
      in_valid = 1'b0;
      drain();
      check("t5_count", 64'(got.size()), 64'(1));
      if (got.size() == 1) begin
         check("t5_tag",  64'(got[0].tag),  64'(42));
         check("t5_data", 64'(got[0].data), 64'h0F00_0F00);
      end

`ifdef ISSUEINT_FLUSH_EN
      // Flush squashes both in-flight ops and the op offered in the flush cycle.
      got.delete();
      out_ready = 1'b0;
      issue(OPC_ADD, 32'd1, 32'd2, 6'd50);
      issue(OPC_ADD, 32'd3, 32'd4, 6'd51);
      in_opcode = OPC_ADD;
      in_rdtag  = 6'd52;
      flush = 1'b1;
      @(negedge clk);
      check("t6_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      check("t6_out_valid", 64'(out_valid), 64'(0));
      check("t6_busy", 64'(busy), 64'(0));
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t6_count", 64'(got.size()), 64'(0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
